// File: rtl/burst_copy_dma_pkg.sv
// Shared types and address-math helpers for the burst copy DMA.
package burst_copy_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_t;

  // log2 of bytes per word: shift that turns a word index into a byte offset
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // log2 of bytes per burst: shift that turns a burst index into a byte offset
  function automatic int burst_shift(input int data_width, input int burst_length);
    return $clog2(burst_length) + byte_shift(data_width);
  endfunction

endpackage

// File: rtl/burst_copy_dma_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
// Read data is forced to zero while empty so the write port never shows stale words.
module dma_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop   = i_rd & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // storage array; no reset needed since empty masks the read data
  always_ff @(posedge clock) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  // pointers and occupancy; flush behaves like reset
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr)  r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      if (i_wr && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!i_wr && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(i_wr && !i_flush && !w_pop && (r_count == CNT_FULL)));

endmodule

// File: rtl/burst_copy_dma.sv
// Burst-read DMA: fetches fixed-length bursts from a source port into a FIFO
// and drains them word by word to a destination write port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; FIFO held flushed
// ST_RUN   | issuing bursts and writing words until the last word is taken
// ST_DRAIN | aborted with a burst in flight; swallow beats until burstDone
module burst_copy_dma
  import burst_copy_dma_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int COUNT_WIDTH  = 18
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_start,
  input  logic                   io_abort,
  input  logic [ADDR_WIDTH-1:0]  io_src_base,
  input  logic [ADDR_WIDTH-1:0]  io_dst_base,
  input  logic [COUNT_WIDTH-1:0] io_num_bursts,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_in_rd,
  output logic [ADDR_WIDTH-1:0]  io_in_addr,
  input  logic [DATA_WIDTH-1:0]  io_in_dout,
  input  logic                   io_in_wait_n,
  input  logic                   io_in_valid,
  input  logic                   io_in_burstDone,
  output logic                   io_out_wr,
  output logic [ADDR_WIDTH-1:0]  io_out_addr,
  output logic [DATA_WIDTH-1:0]  io_out_din,
  input  logic                   io_out_wait_n
);

  localparam int BYTE_SH  = byte_shift(DATA_WIDTH);
  localparam int BURST_SH = burst_shift(DATA_WIDTH, BURST_LENGTH);
  localparam int LOG_BL   = $clog2(BURST_LENGTH);
  localparam int TW       = COUNT_WIDTH + LOG_BL;
  localparam int FCW      = $clog2(FIFO_DEPTH) + 1;
  // a new burst is only requested when a whole burst is guaranteed to fit
  localparam logic [FCW-1:0] RD_LIMIT = FCW'(FIFO_DEPTH - BURST_LENGTH);

  dma_state_t             r_state;
  logic [ADDR_WIDTH-1:0]  r_src_base;
  logic [ADDR_WIDTH-1:0]  r_dst_base;
  logic [COUNT_WIDTH-1:0] r_num_bursts;
  logic [COUNT_WIDTH-1:0] r_burst_idx;
  logic [TW-1:0]          r_word_idx;
  logic                   r_pending;
  logic                   r_done;

  logic                   w_run;
  logic                   w_start;
  logic                   w_in_rd;
  logic                   w_rd_acc;
  logic                   w_pending_nxt;
  logic                   w_enq;
  logic                   w_out_wr;
  logic                   w_wr_acc;
  logic                   w_last;
  logic                   w_fifo_flush;
  logic                   w_fifo_empty;
  logic [FCW-1:0]         w_fifo_count;
  logic [DATA_WIDTH-1:0]  w_fifo_head;
  logic [TW-1:0]          w_total_m1;

  assign w_run      = (r_state == ST_RUN);
  assign w_start    = (r_state == ST_IDLE) & io_start & ~io_abort;
  assign w_total_m1 = (TW'(r_num_bursts) << LOG_BL) - TW'(1);

  assign w_in_rd  = w_run & ~r_pending & (r_burst_idx < r_num_bursts)
                  & (w_fifo_count <= RD_LIMIT);
  assign w_rd_acc = w_in_rd & io_in_wait_n;
  // burstDone wins over a new accept
  assign w_pending_nxt = io_in_burstDone ? 1'b0 : (w_rd_acc ? 1'b1 : r_pending);
  assign w_enq    = io_in_valid & r_pending & w_run;

  assign w_out_wr = w_run & ~w_fifo_empty;
  assign w_wr_acc = w_out_wr & io_out_wait_n;
  assign w_last   = w_wr_acc & (r_word_idx == w_total_m1);

  // outside RUN the FIFO is continuously emptied, covering start and abort
  assign w_fifo_flush = ~w_run;

  assign io_busy     = (r_state == ST_RUN) | (r_state == ST_DRAIN);
  assign io_done     = r_done;
  assign io_in_rd    = w_in_rd;
  assign io_in_addr  = r_src_base + (ADDR_WIDTH'(r_burst_idx) << BURST_SH);
  assign io_out_wr   = w_out_wr;
  assign io_out_addr = r_dst_base + (ADDR_WIDTH'(r_word_idx) << BYTE_SH);
  assign io_out_din  = w_fifo_head;

  dma_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_flush (w_fifo_flush),
    .i_wr    (w_enq),
    .i_wdata (io_in_dout),
    .i_rd    (w_wr_acc),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  // sequencing FSM, transfer counters and the done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_src_base   <= '0;
      r_dst_base   <= '0;
      r_num_bursts <= '0;
      r_burst_idx  <= '0;
      r_word_idx   <= '0;
      r_pending    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_pending <= w_pending_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_src_base   <= io_src_base;
            r_dst_base   <= io_dst_base;
            r_num_bursts <= io_num_bursts;
            r_burst_idx  <= '0;
            r_word_idx   <= '0;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (io_abort) begin
            // a request accepted in the abort cycle still has beats coming
            r_state <= w_pending_nxt ? ST_DRAIN : ST_IDLE;
          end else if (r_num_bursts == '0) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            if (r_pending && io_in_burstDone) r_burst_idx <= r_burst_idx + COUNT_WIDTH'(1);
            if (w_wr_acc) r_word_idx <= r_word_idx + TW'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (io_in_burstDone) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
